force_cache_readout: RTL and testbench
======================================

FORCE_CACHE_READOUT -- requirements
Module: force_cache_readout

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bit width of one force component (FP32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, force-cache address width (depth 128).
REQ-003 SHALL have parameter RD_LATENCY, default 2, cache read latency in cycles (registered M20K).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a drain.
REQ-007 SHALL have port particle_count  in  ADDR_WIDTH+1  entries to drain, 0..2^ADDR_WIDTH, sampled on accepted start.
REQ-008 SHALL have port busy  out  1  high from accepted start until done.
REQ-009 SHALL have port done  out  1  one-cycle pulse when the drain completes.
REQ-010 SHALL have port cache_rd_en  out  1  cache read strobe.
REQ-011 SHALL have port cache_rd_addr  out  ADDR_WIDTH  cache read address.
REQ-012 SHALL have port cache_rd_data  in  3*DATA_WIDTH  {Fz,Fy,Fx}, valid RD_LATENCY cycles after cache_rd_en.
REQ-013 SHALL have port cache_wr_en  out  1  clear-write strobe.
REQ-014 SHALL have port cache_wr_addr  out  ADDR_WIDTH  clear-write address.
REQ-015 SHALL have port cache_wr_data  out  3*DATA_WIDTH  constant zero.
REQ-016 SHALL have port out_valid  out  1  output record valid.
REQ-017 SHALL have port out_ready  in  1  downstream accepts the record.
REQ-018 SHALL have port out_force  out  3*DATA_WIDTH  force record {Fz,Fy,Fx}.
REQ-019 SHALL have port out_particle_id  out  ADDR_WIDTH  cache address the record came from.

Function
REQ-020 SHALL implement the FSM states IDLE, DRAIN, FLUSH, DONE.
REQ-021 IDLE->DRAIN on start when particle_count>0; IDLE->DONE on start when particle_count=0.
REQ-022 start while busy SHALL be ignored.
REQ-023 In DRAIN, the read address SHALL run 0,1,...,particle_count-1, one read per cycle while credits are available.
REQ-024 Credits SHALL be counted as in-flight reads plus skid occupancy; reads SHALL be issued only while that sum is below SKID_DEPTH (4).
REQ-025 Returning data SHALL enter the skid FIFO together with its pipelined address; no returning read SHALL ever be dropped.
REQ-026 Each returning read SHALL write zero to the same address (cache_wr_en) on the cycle its data arrives, leaving the cache cleared for the next iteration.
REQ-027 DRAIN->FLUSH after the last read is issued; FLUSH->DONE when nothing is in flight and the skid FIFO is empty; DONE->IDLE after one cycle, with done=1 for that cycle.
REQ-028 An output transfer SHALL occur when out_valid&&out_ready; out_valid SHALL stay high and out_force/out_particle_id SHALL stay stable until the transfer.
REQ-029 Records SHALL leave in strictly increasing address order, exactly particle_count records per drain.
REQ-030 With out_ready held at 1, throughput SHALL be 1 record/cycle, and the first out_valid SHALL assert RD_LATENCY+1 cycles after start.
REQ-031 A simultaneous skid push and pop SHALL leave occupancy unchanged; particle_count=2^ADDR_WIDTH SHALL drain all entries with no address wrap or repeat.

Reset
REQ-032 While rst=0: FSM=IDLE; busy, done, cache_rd_en, cache_wr_en and out_valid SHALL be 0; addresses, counters and skid occupancy SHALL be 0; out_force SHALL be 0.
REQ-033 Reset asserted mid-drain SHALL abort immediately; in-flight reads SHALL be discarded, and entries not yet cleared remain unchanged.

Structure
REQ-034 Package md_readout_pkg SHALL hold DATA_WIDTH, FORCE_WIDTH (=3*DATA_WIDTH), SKID_DEPTH=4 and the FSM state encoding.
REQ-035 Sub-module force_skid_fifo SHALL implement the 4-entry first-word-fall-through skid buffer with width FORCE_WIDTH+ADDR_WIDTH.

Verification
REQ-036 particle_count=5, out_ready=1, cache[i]=i+1 per component -> out_valid first at cycle 3, then 5 consecutive records with ids 0..4; done 1 cycle after the last; cache[0..4]=0.
REQ-037 particle_count=8, out_ready toggling 1,0,1,0 -> no loss or duplication; the in-flight+skid count never exceeds 4; ids 0..7 in order.
REQ-038 particle_count=0 -> busy high 1 cycle, done pulse on cycle 1, no cache_rd_en or cache_wr_en.
REQ-039 particle_count=128, out_ready=0 for 20 cycles then 1 -> exactly 4 reads outstanding during the stall; all 128 records emitted; the last id is 127.
REQ-040 rst=0 at record 3 of 10 -> all outputs 0 next edge; after release, a new start with count 2 yields ids 0,1 only.
REQ-041 A second start pulse mid-drain -> ignored; the record count equals the first particle_count.

Source files
------------

// File: rtl/md_readout_pkg.sv
// -----------------------------------------------------------------------------
// md_readout_pkg
// Shared constants and types for the force-cache readout block.
//   DATA_WIDTH  : width of one force component (FP32 bit pattern)
//   FORCE_WIDTH : one {Fz,Fy,Fx} record
//   SKID_DEPTH  : skid buffer entries; also the cap on reads outstanding
//   state_e     : readout FSM encoding
// -----------------------------------------------------------------------------
package md_readout_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int FORCE_WIDTH = 3 * DATA_WIDTH;
    localparam int SKID_DEPTH  = 4;
    localparam int SKID_PTR_W  = $clog2(SKID_DEPTH);
    localparam int SKID_CNT_W  = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/force_skid_fifo.sv
// -----------------------------------------------------------------------------
// force_skid_fifo
// SKID_DEPTH-entry first-word-fall-through buffer that catches returning cache
// reads so none are lost while the downstream consumer stalls.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   push, push_data   : write one entry (ignored when full)
//   pop               : consume the head entry (ignored when empty)
//   pop_data          : head entry, valid whenever not_empty is high
//   not_empty         : buffer holds at least one entry
//   count             : current occupancy
// -----------------------------------------------------------------------------
module force_skid_fifo
    import md_readout_pkg::*;
#(
    parameter int WIDTH = FORCE_WIDTH + 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  not_empty,
    output logic [SKID_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      mem_q [SKID_DEPTH];
    logic [WIDTH-1:0]      mem_d [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SKID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [SKID_CNT_W-1:0] count_q, count_d;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Next-state: push fills the tail slot, pop advances the head; both at once keep occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && (count_q != SKID_CNT_W'(SKID_DEPTH));
        do_pop_s  = pop && (count_q != {SKID_CNT_W{1'b0}});
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + SKID_PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + SKID_PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + SKID_CNT_W'(1);
            2'b01:   count_d = count_q - SKID_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy; storage is cleared so the head reads zero in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data  = mem_q[rd_ptr_q];
    assign not_empty = (count_q != {SKID_CNT_W{1'b0}});
    assign count     = count_q;

endmodule

// File: rtl/force_cache_readout.sv
// -----------------------------------------------------------------------------
// force_cache_readout
// Drains entries 0..particle_count-1 of the force cache in address order,
// streams each {Fz,Fy,Fx} record out over a valid/ready handshake and writes
// zero back to every entry as its data returns, leaving the cache cleared.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   start, particle_count         : begin a drain of particle_count entries
//   busy, done                    : drain in progress / one-cycle completion
//   cache_rd_en/addr/data         : cache read port, data RD_LATENCY cycles later
//   cache_wr_en/addr/data         : clear-write port (data always zero)
//   out_valid/ready/force/particle_id : output record stream
// The first read is issued in the start cycle so that, with a registered skid
// buffer, the first record is presented RD_LATENCY+1 cycles after start.
// -----------------------------------------------------------------------------
module force_cache_readout #(
    parameter int DATA_WIDTH = md_readout_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 7,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     particle_count,
    output logic                    busy,
    output logic                    done,
    output logic                    cache_rd_en,
    output logic [ADDR_WIDTH-1:0]   cache_rd_addr,
    input  logic [3*DATA_WIDTH-1:0] cache_rd_data,
    output logic                    cache_wr_en,
    output logic [ADDR_WIDTH-1:0]   cache_wr_addr,
    output logic [3*DATA_WIDTH-1:0] cache_wr_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3*DATA_WIDTH-1:0] out_force,
    output logic [ADDR_WIDTH-1:0]   out_particle_id
);
    import md_readout_pkg::*;

    localparam int FW    = 3 * DATA_WIDTH;
    localparam int REC_W = FW + ADDR_WIDTH;
    localparam int SUM_W = SKID_CNT_W + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [SKID_CNT_W-1:0] inflight_q, inflight_d;
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [ADDR_WIDTH-1:0] pipe_addr_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_addr_d [RD_LATENCY];
    logic [SKID_CNT_W-1:0] skid_count_s;
    logic [REC_W-1:0]      skid_out_s;
    logic                  credit_ok_s;
    logic                  issue_s;
    logic                  arrive_s;
    logic                  pop_s;
    logic                  skid_drains_s;

    // A read needs a guaranteed skid slot: in-flight reads plus buffered records stay below the depth.
    assign credit_ok_s = ({1'b0, inflight_q} + {1'b0, skid_count_s}) < SUM_W'(SKID_DEPTH);
    assign arrive_s    = pipe_vld_q[RD_LATENCY-1];
    assign pop_s       = out_valid && out_ready;
    // No push can occur once nothing is in flight, so a pop of the last entry empties the buffer.
    assign skid_drains_s = (skid_count_s == {SKID_CNT_W{1'b0}}) ||
                           ((skid_count_s == SKID_CNT_W'(1)) && pop_s);

    // FSM next state, read issue and address/count bookkeeping.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q;
        issue_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = particle_count;
                    if (particle_count == {(ADDR_WIDTH+1){1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        issue_s = credit_ok_s;
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
                if (issue_s) begin
                    rd_addr_d = rd_addr_q + (ADDR_WIDTH+1)'(1);
                end else begin
                    rd_addr_d = rd_addr_q;
                end
            end
            S_DRAIN: begin
                if (rd_addr_q < count_q) begin
                    issue_s = credit_ok_s;
                end else begin
                    issue_s = 1'b0;
                end
                if (issue_s) begin
                    rd_addr_d = rd_addr_q + (ADDR_WIDTH+1)'(1);
                end else begin
                    rd_addr_d = rd_addr_q;
                end
                if (rd_addr_d == count_q) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FLUSH: begin
                if ((inflight_q == {SKID_CNT_W{1'b0}}) && skid_drains_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                rd_addr_d = '0;
                count_d   = '0;
            end
            default: begin
                state_d   = S_IDLE;
                rd_addr_d = '0;
                count_d   = '0;
            end
        endcase
    end

    // Read-return tracking: a valid/address pipe matching the cache latency plus an in-flight count.
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_addr_d    = pipe_addr_q;
        pipe_vld_d[0]  = issue_s;
        pipe_addr_d[0] = rd_addr_q[ADDR_WIDTH-1:0];
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end
        inflight_d = inflight_q + SKID_CNT_W'(issue_s) - SKID_CNT_W'(arrive_s);
    end

    // Control state registers; reset drops any reads still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_addr_q <= pipe_addr_d;
        end
    end

    force_skid_fifo #(
        .WIDTH (REC_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (arrive_s),
        .push_data ({cache_rd_data, pipe_addr_q[RD_LATENCY-1]}),
        .pop       (pop_s),
        .pop_data  (skid_out_s),
        .not_empty (out_valid),
        .count     (skid_count_s)
    );

    // The start-cycle read depends on the start input, so hold it off while reset is asserted.
    assign cache_rd_en     = issue_s && rst;
    assign cache_rd_addr   = rd_addr_q[ADDR_WIDTH-1:0];
    assign cache_wr_en     = arrive_s;
    assign cache_wr_addr   = pipe_addr_q[RD_LATENCY-1];
    assign cache_wr_data   = '0;
    assign out_force       = skid_out_s[REC_W-1:ADDR_WIDTH];
    assign out_particle_id = skid_out_s[ADDR_WIDTH-1:0];
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_force_cache_readout.sv
// -----------------------------------------------------------------------------
// tb_force_cache_readout
// Table of drain scenarios plus hand-written restart and reset-abort sequences.
// A behavioural cache with a two-cycle read pipe backs the DUT; expected records
// are queued when start is driven and compared as each transfer happens.
// Cycle 0 is the cycle in which start is high.
// -----------------------------------------------------------------------------
module tb_force_cache_readout;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int RL    = 2;
    localparam int FW    = 3 * DW;
    localparam int N_ENT = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   particle_count = '0;
    logic          busy, done;
    logic          cache_rd_en, cache_wr_en;
    logic [AW-1:0] cache_rd_addr, cache_wr_addr;
    logic [FW-1:0] cache_rd_data, cache_wr_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] out_force;
    logic [AW-1:0] out_particle_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    force_cache_readout #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (RL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .particle_count  (particle_count),
        .busy            (busy),
        .done            (done),
        .cache_rd_en     (cache_rd_en),
        .cache_rd_addr   (cache_rd_addr),
        .cache_rd_data   (cache_rd_data),
        .cache_wr_en     (cache_wr_en),
        .cache_wr_addr   (cache_wr_addr),
        .cache_wr_data   (cache_wr_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_force       (out_force),
        .out_particle_id (out_particle_id)
    );

    // Record pattern: salt 0 gives i+1 in every component.
    function automatic logic [FW-1:0] pat(input int i, input int salt);
        logic [31:0] b;
        b = 32'(i + 1);
        return {b + 32'(3 * salt * 1000), b + 32'(2 * salt * 1000), b + 32'(salt * 1000)};
    endfunction

    // Behavioural cache: registered read with RL cycles latency, clear writes, bulk fill.
    logic [FW-1:0] mem [N_ENT];
    logic          fill_req  = 1'b0;
    int            fill_salt = 0;
    logic [FW-1:0] p1_q = '0;
    logic [FW-1:0] p2_q = '0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < N_ENT; i++) mem[i] <= pat(i, fill_salt);
        end else if (cache_wr_en) begin
            mem[cache_wr_addr] <= cache_wr_data;
        end
        p1_q <= cache_rd_en ? mem[cache_rd_addr] : '0;
        p2_q <= p1_q;
    end
    assign cache_rd_data = p2_q;

    typedef struct {
        logic [AW-1:0] id;
        logic [FW-1:0] f;
    } rec_t;
    rec_t sb_q[$];

    typedef struct {
        int n;
        int mode;       // 0 ready=1, 1 toggle, 2 stall 20 cycles, 3 random
        int salt;
        int exp_first;  // first out_valid cycle, -1 = never
        int exp_done;   // done cycle, -1 = not checked
        int restart_at; // cycle of an extra start pulse, -1 = none
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            2:       return c >= 20;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, ".busy"},      busy, 1'b0);
        check({tag, ".done"},      done, 1'b0);
        check({tag, ".rd_en"},     cache_rd_en, 1'b0);
        check({tag, ".wr_en"},     cache_wr_en, 1'b0);
        check({tag, ".out_valid"}, out_valid, 1'b0);
        check({tag, ".out_force"}, out_force, '0);
        check({tag, ".out_id"},    out_particle_id, '0);
        check({tag, ".rd_addr"},   cache_rd_addr, '0);
        check({tag, ".wr_addr"},   cache_wr_addr, '0);
    endtask

    task automatic fill(input int salt);
        @(negedge clk);
        fill_salt = salt;
        fill_req  = 1'b1;
        @(negedge clk);
        fill_req  = 1'b0;
    endtask

    task automatic run_drain(input string tag, input vec_t v, input int abort_at);
        int c, first_c, done_c, reads, writes, recs, outstanding, max_out, bad;
        logic busy_ok, stall_ok, held, exp_busy;
        logic [AW-1:0] held_id;
        logic [FW-1:0] held_f;
        rec_t e;
        fill(v.salt);
        sb_q.delete();
        @(negedge clk);
        start          = 1'b1;
        particle_count = v.n[AW:0];
        out_ready      = ready_for(v.mode, 0);
        for (int i = 0; i < v.n; i++) sb_q.push_back('{id: AW'(i), f: pat(i, v.salt)});
        c = 0; first_c = -1; done_c = -1; reads = 0; writes = 0; recs = 0; max_out = 0;
        busy_ok = 1'b1; stall_ok = 1'b1; held = 1'b0; held_id = '0; held_f = '0;
        while (c < 2000) begin
            if (c == abort_at) rst = 1'b0;
            #1;
            if (c == abort_at) break;
            if (out_valid && first_c < 0) first_c = c;
            if (held) begin
                check($sformatf("%s.hold_valid@%0d", tag, c), out_valid, 1'b1);
                check($sformatf("%s.hold_id@%0d", tag, c), out_particle_id, held_id);
                check($sformatf("%s.hold_force@%0d", tag, c), out_force, held_f);
            end
            held    = out_valid && !out_ready;
            held_id = out_particle_id;
            held_f  = out_force;
            outstanding = reads - recs;
            if (outstanding > max_out) max_out = outstanding;
            if (v.mode == 2 && c >= 4 && c < 20 && outstanding != 4) stall_ok = 1'b0;
            if (cache_rd_en) reads++;
            if (cache_wr_en) writes++;
            if (out_valid && out_ready) begin
                recs++;
                if (sb_q.size() == 0) begin
                    check($sformatf("%s.extra_record@%0d", tag, c), 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("%s.id@%0d", tag, c), out_particle_id, e.id);
                    check($sformatf("%s.force@%0d", tag, c), out_force, e.f);
                end
            end
            exp_busy = (c != 0) && (done_c < 0);
            if (busy !== exp_busy) busy_ok = 1'b0;
            if (done) begin
                if (done_c >= 0) busy_ok = 1'b0;
                done_c = c;
            end
            if (done_c >= 0 && c == done_c + 1) break;
            @(negedge clk);
            c++;
            if (c == v.restart_at) begin
                start = 1'b1;
                particle_count = 3;
            end else begin
                start = 1'b0;
            end
            out_ready = ready_for(v.mode, c);
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            check_quiet({tag, ".abort"});
            check({tag, ".abort_recs"}, recs, abort_at - 3);
            bad = 0;
            for (int i = 0; i < v.n; i++) begin
                if (mem[i] !== ((i < abort_at - 2) ? '0 : pat(i, v.salt))) bad++;
            end
            check({tag, ".abort_cache"}, bad, 0);
        end else begin
            check({tag, ".done_seen"}, done_c >= 0, 1'b1);
            check({tag, ".first_valid"}, first_c, v.exp_first);
            if (v.exp_done >= 0) check({tag, ".done_cycle"}, done_c, v.exp_done);
            check({tag, ".records"}, recs, v.n);
            check({tag, ".reads"}, reads, v.n);
            check({tag, ".writes"}, writes, v.n);
            check({tag, ".busy"}, busy_ok, 1'b1);
            check({tag, ".max_outstanding_le4"}, max_out <= 4, 1'b1);
            if (v.mode == 2) check({tag, ".stall_outstanding4"}, stall_ok, 1'b1);
            bad = 0;
            for (int i = 0; i < v.n; i++) if (mem[i] !== '0) bad++;
            check({tag, ".cleared"}, bad, 0);
            if (v.n < N_ENT) check({tag, ".untouched"}, mem[v.n], pat(v.n, v.salt));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{n: 5,   mode: 0, salt: 0, exp_first: 3,  exp_done: 8,  restart_at: -1};
        vecs[1] = '{n: 8,   mode: 1, salt: 1, exp_first: 3,  exp_done: -1, restart_at: -1};
        vecs[2] = '{n: 0,   mode: 0, salt: 2, exp_first: -1, exp_done: 1,  restart_at: -1};
        vecs[3] = '{n: 128, mode: 2, salt: 3, exp_first: 3,  exp_done: -1, restart_at: -1};
        vecs[4] = '{n: 1,   mode: 0, salt: 4, exp_first: 3,  exp_done: 4,  restart_at: -1};
        vecs[5] = '{n: 17,  mode: 0, salt: 5, exp_first: 3,  exp_done: 20, restart_at: -1};
        vecs[6] = '{n: 6,   mode: 3, salt: 6, exp_first: 3,  exp_done: -1, restart_at: -1};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("por");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) run_drain($sformatf("vec%0d", i), vecs[i], -1);

        // Extra start pulse in cycle 2 of a 7-entry drain must be ignored.
        run_drain("restart", '{n: 7, mode: 0, salt: 7, exp_first: 3, exp_done: 10, restart_at: 2}, -1);

        // Reset in cycle 6 of a 10-entry drain, after records 0..2 have left.
        run_drain("abort", '{n: 10, mode: 0, salt: 8, exp_first: 3, exp_done: -1, restart_at: -1}, 6);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_drain("post_abort", '{n: 2, mode: 0, salt: 9, exp_first: 3, exp_done: 5, restart_at: -1}, -1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
